// File: rtl/spi_xfer_sequencer.sv
// Wishbone master that runs one spi_top character transfer per request descriptor.
// It programs ctrl/divider/ss/tx, sets go, polls go_busy, then reads rx and responds.
module spi_xfer_sequencer #(
  parameter int unsigned SS_NB   = 8,
  parameter int unsigned ACK_TO  = 16,
  parameter int unsigned XFER_TO = 4096
) (
  input  logic             wb_clk_in,
  input  logic             wb_rst_n_in,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [6:0]       req_char_len,
  input  logic [2:0]       req_mode,
  input  logic [15:0]      req_div,
  input  logic [SS_NB-1:0] req_ss,
  input  logic [31:0]      req_tx,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_rx,
  output logic             rsp_err,
  output logic [4:0]       wb_adr_o,
  output logic [31:0]      wb_dat_o,
  output logic [3:0]       wb_sel_o,
  output logic             wb_we_o,
  output logic             wb_stb_o,
  output logic             wb_cyc_o,
  input  logic [31:0]      wb_dat_i,
  input  logic             wb_ack_i,
  input  logic             wb_err_i
);

  localparam int unsigned AckW  = $clog2(ACK_TO + 1);
  localparam int unsigned PollW = $clog2(XFER_TO + 1);

  typedef enum logic [3:0] {
    StIdle, StWrCtrl, StWrDiv, StWrSs, StWrTx, StWrGo, StPoll, StRdRx, StAbort, StResp
  } state_e;
  typedef enum logic [1:0] {PhSetup, PhAccess, PhDone} phase_e;

  state_e            state_q, state_d;
  phase_e            phase_q, phase_d;
  logic [AckW-1:0]   acnt_q, acnt_d;
  logic [PollW-1:0]  pcnt_q, pcnt_d;
  logic              busy_q, busy_d;
  logic [31:0]       rx_q, rx_d;
  logic              err_q, err_d;
  logic              live_q;
  logic              latch_en;
  logic [6:0]        len_q;
  logic [2:0]        mode_q;
  logic [15:0]       div_q;
  logic [SS_NB-1:0]  ss_q;
  logic [31:0]       tx_q;

  logic [32:0] mask33;
  logic [31:0] ctrl_nogo, ctrl_go;
  logic        ack_to, xfer_to, access;

  assign mask33    = (33'd1 << len_q) - 33'd1;
  assign ctrl_nogo = {18'd0, 1'b1, 1'b0, mode_q, 1'b0, 1'b0, len_q};
  assign ctrl_go   = ctrl_nogo | 32'h0000_0100;
  assign ack_to    = (acnt_q == AckW'(ACK_TO - 1));
  assign xfer_to   = (state_q == StPoll) && (pcnt_q == PollW'(XFER_TO - 1));

  always_ff @(posedge wb_clk_in or negedge wb_rst_n_in) begin
    if (!wb_rst_n_in) begin
      state_q <= StIdle;
      phase_q <= PhSetup;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    acnt_d   = acnt_q;
    pcnt_d   = (state_q == StPoll) ? pcnt_q + PollW'(1) : '0;
    busy_d   = busy_q;
    rx_d     = rx_q;
    err_d    = err_q;
    latch_en = 1'b0;
    case (state_q)
      StIdle: begin
        if (req_valid && live_q) begin
          latch_en = 1'b1;
          rx_d     = '0;
          phase_d  = PhSetup;
          if (req_char_len == 7'd0 || req_char_len > 7'd32) begin
            state_d = StResp;
            err_d   = 1'b1;
          end else begin
            state_d = StWrCtrl;
            err_d   = 1'b0;
          end
        end
      end
      StResp: begin
        if (rsp_ready) state_d = StIdle;
      end
      default: begin
        case (phase_q)
          PhSetup: begin
            phase_d = PhAccess;
            acnt_d  = '0;
          end
          PhAccess: begin
            if (wb_err_i || (ack_to && !wb_ack_i)) begin
              phase_d = PhSetup;
              // Ack timeouts after go was set must try to clear go before giving up.
              if (!wb_err_i && (state_q == StWrGo || state_q == StPoll)) begin
                state_d = StAbort;
              end else begin
                state_d = StResp;
                err_d   = 1'b1;
                rx_d    = '0;
              end
            end else if (wb_ack_i) begin
              phase_d = PhDone;
              busy_d  = wb_dat_i[8];
              if (state_q == StRdRx) rx_d = wb_dat_i & mask33[31:0];
            end else begin
              acnt_d = acnt_q + AckW'(1);
            end
          end
          default: begin
            phase_d = PhSetup;
            case (state_q)
              StWrCtrl: state_d = StWrDiv;
              StWrDiv:  state_d = StWrSs;
              StWrSs:   state_d = StWrTx;
              StWrTx:   state_d = StWrGo;
              StWrGo:   state_d = StPoll;
              StPoll: begin
                if (busy_q) begin
                  phase_d = PhAccess;
                  acnt_d  = '0;
                end else begin
                  state_d = StRdRx;
                end
              end
              StRdRx:   state_d = StResp;
              default: begin
                state_d = StResp;
                err_d   = 1'b1;
                rx_d    = '0;
              end
            endcase
          end
        endcase
        if (xfer_to) begin
          state_d = StAbort;
          phase_d = PhSetup;
        end
      end
    endcase
  end

  always_ff @(posedge wb_clk_in or negedge wb_rst_n_in) begin
    if (!wb_rst_n_in) begin
      acnt_q <= '0;
      pcnt_q <= '0;
      busy_q <= 1'b0;
      rx_q   <= '0;
      err_q  <= 1'b0;
      live_q <= 1'b0;
      len_q  <= '0;
      mode_q <= '0;
      div_q  <= '0;
      ss_q   <= '0;
      tx_q   <= '0;
    end else begin
      acnt_q <= acnt_d;
      pcnt_q <= pcnt_d;
      busy_q <= busy_d;
      rx_q   <= rx_d;
      err_q  <= err_d;
      live_q <= 1'b1;
      if (latch_en) begin
        len_q  <= req_char_len;
        mode_q <= req_mode;
        div_q  <= req_div;
        ss_q   <= req_ss;
        tx_q   <= req_tx;
      end
    end
  end

  always_comb begin
    access    = (phase_q == PhAccess) && (state_q != StIdle) && (state_q != StResp);
    wb_cyc_o  = access;
    wb_stb_o  = access;
    wb_sel_o  = access ? 4'hF : 4'h0;
    wb_we_o   = 1'b0;
    wb_adr_o  = 5'h00;
    wb_dat_o  = 32'h0;
    if (access) begin
      case (state_q)
        StWrCtrl: begin wb_we_o = 1'b1; wb_adr_o = 5'h10; wb_dat_o = ctrl_nogo;        end
        StWrDiv:  begin wb_we_o = 1'b1; wb_adr_o = 5'h14; wb_dat_o = {16'd0, div_q};   end
        StWrSs:   begin wb_we_o = 1'b1; wb_adr_o = 5'h18; wb_dat_o = 32'(ss_q);        end
        StWrTx:   begin wb_we_o = 1'b1; wb_adr_o = 5'h00; wb_dat_o = tx_q;             end
        StWrGo:   begin wb_we_o = 1'b1; wb_adr_o = 5'h10; wb_dat_o = ctrl_go;          end
        StPoll:   wb_adr_o = 5'h10;
        StAbort:  begin wb_we_o = 1'b1; wb_adr_o = 5'h10; wb_dat_o = ctrl_nogo;        end
        default:  wb_adr_o = 5'h00;
      endcase
    end
    req_ready = (state_q == StIdle) && live_q;
    rsp_valid = (state_q == StResp);
    rsp_rx    = rsp_valid ? rx_q : 32'h0;
    rsp_err   = rsp_valid && err_q;
  end

endmodule

// File: tb/tb_spi_xfer_sequencer.sv
// Directed bench for spi_xfer_sequencer with a combinational Wishbone slave model
// that logs completed accesses and can stall, error or keep go_busy set.
module tb_spi_xfer_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [6:0]  req_char_len = '0;
  logic [2:0]  req_mode = '0;
  logic [15:0] req_div = '0;
  logic [7:0]  req_ss = '0;
  logic [31:0] req_tx = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rx;
  logic        rsp_err;
  logic [4:0]  wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [3:0]  wb_sel_o;
  logic        wb_we_o, wb_stb_o, wb_cyc_o;
  logic [31:0] wb_dat_i;
  logic        wb_ack_i, wb_err_i;

  // Slave knobs, written only by the stimulus process.
  logic        noack_en = 1'b0;
  logic [4:0]  noack_adr = '0;
  logic        err_en = 1'b0;
  logic [4:0]  err_adr = '0;
  logic        busy_forever = 1'b0;
  int          busy_until = 0;
  logic [31:0] rx_word = '0;

  // Slave observations, written only by the monitor process.
  int          poll_reads = 0;
  int          cyc_cnt = 0;
  int          cyc_total = 0;
  int          cur_run = 0;
  int          last_run = 0;
  logic        log_we[$];
  logic [4:0]  log_adr[$];
  logic [31:0] log_dat[$];

  int n_checks = 0;
  int n_fail = 0;

  spi_xfer_sequencer #(.SS_NB(8), .ACK_TO(16), .XFER_TO(4096)) dut (
    .wb_clk_in   (clk),
    .wb_rst_n_in (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_char_len(req_char_len),
    .req_mode    (req_mode),
    .req_div     (req_div),
    .req_ss      (req_ss),
    .req_tx      (req_tx),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_rx      (rsp_rx),
    .rsp_err     (rsp_err),
    .wb_adr_o    (wb_adr_o),
    .wb_dat_o    (wb_dat_o),
    .wb_sel_o    (wb_sel_o),
    .wb_we_o     (wb_we_o),
    .wb_stb_o    (wb_stb_o),
    .wb_cyc_o    (wb_cyc_o),
    .wb_dat_i    (wb_dat_i),
    .wb_ack_i    (wb_ack_i),
    .wb_err_i    (wb_err_i)
  );

  always #5 clk = ~clk;

  assign wb_err_i = wb_stb_o && err_en && (wb_adr_o == err_adr);
  assign wb_ack_i = wb_stb_o && !wb_err_i && !(noack_en && (wb_adr_o == noack_adr));
  assign wb_dat_i = (wb_adr_o == 5'h00) ? rx_word :
                    (wb_adr_o == 5'h10) ?
                      ((busy_forever || (poll_reads < busy_until)) ? 32'h100 : 32'h0) : 32'h0;

  always @(posedge clk) begin
    cyc_cnt <= cyc_cnt + 1;
    if (wb_cyc_o) cyc_total <= cyc_total + 1;
    if (wb_stb_o && wb_ack_i) begin
      log_we.push_back(wb_we_o);
      log_adr.push_back(wb_adr_o);
      log_dat.push_back(wb_dat_o);
      if (!wb_we_o && wb_adr_o == 5'h10) poll_reads <= poll_reads + 1;
    end
    if (wb_stb_o) cur_run <= cur_run + 1;
    else if (cur_run != 0) begin
      last_run <= cur_run;
      cur_run  <= 0;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic send_req(input logic [6:0] len, input logic [2:0] mode, input logic [15:0] div,
                          input logic [7:0] ss, input logic [31:0] tx, output int t0);
    int n;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) check_eq("req_ready_wait", 32'(req_ready), 32'd1);
    req_char_len = len;
    req_mode     = mode;
    req_div      = div;
    req_ss       = ss;
    req_tx       = tx;
    req_valid    = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    t0 = cyc_cnt;
  endtask

  task automatic run_xfer(input string t, input logic [6:0] len, input logic [2:0] mode,
                          input logic [15:0] div, input logic [7:0] ss, input logic [31:0] tx,
                          input int hold, input logic [31:0] exp_rx, input logic exp_err,
                          output int lat);
    int t0, n;
    send_req(len, mode, div, ss, tx, t0);
    n = 0;
    @(negedge clk);
    while (!rsp_valid && n < 6000) begin
      @(negedge clk);
      n++;
    end
    lat = cyc_cnt - t0;
    if (!rsp_valid) begin
      check_eq({t, "_rsp_wait"}, 32'd0, 32'd1);
    end else begin
      check_eq({t, "_rx"}, rsp_rx, exp_rx);
      check_eq({t, "_err"}, 32'(rsp_err), 32'(exp_err));
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        check_eq({t, "_hold_valid"}, 32'(rsp_valid), 32'd1);
        check_eq({t, "_hold_rx"}, rsp_rx, exp_rx);
        check_eq({t, "_hold_ready"}, 32'(req_ready), 32'd0);
      end
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      rsp_ready = 1'b0;
      check_eq({t, "_valid_drop"}, 32'(rsp_valid), 32'd0);
      check_eq({t, "_ready_back"}, 32'(req_ready), 32'd1);
    end
  endtask

  initial begin
    int base, lat, c0, n, writes;

    // Reset state
    repeat (3) @(negedge clk);
    check_eq("rst_cyc", 32'(wb_cyc_o), 32'd0);
    check_eq("rst_stb", 32'(wb_stb_o), 32'd0);
    check_eq("rst_req_ready", 32'(req_ready), 32'd0);
    check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("rst_adr", 32'(wb_adr_o), 32'd0);
    rst_n = 1'b1;

    // Nominal with two busy polls and 10 cycles of response back-pressure
    base = log_adr.size();
    busy_until = poll_reads + 2;
    rx_word = 32'hFFFF_FFFA;
    run_xfer("nom", 7'd4, 3'b001, 16'd2, 8'd1, 32'h236f, 10, 32'h0000_000A, 1'b0, lat);
    check_eq("nom_nacc", 32'(log_adr.size() - base), 32'd9);
    if (log_adr.size() - base == 9) begin
      check_eq("nom_w0", {log_we[base], 26'd0, log_adr[base]}, {1'b1, 26'd0, 5'h10});
      check_eq("nom_d0", log_dat[base], 32'h2204);
      check_eq("nom_w1", 32'(log_adr[base + 1]), 32'h14);
      check_eq("nom_d1", log_dat[base + 1], 32'h2);
      check_eq("nom_w2", 32'(log_adr[base + 2]), 32'h18);
      check_eq("nom_d2", log_dat[base + 2], 32'h1);
      check_eq("nom_w3", 32'(log_adr[base + 3]), 32'h00);
      check_eq("nom_d3", log_dat[base + 3], 32'h236f);
      check_eq("nom_w4", 32'(log_adr[base + 4]), 32'h10);
      check_eq("nom_d4", log_dat[base + 4], 32'h2304);
      for (int i = 5; i < 8; i++)
        check_eq("nom_poll", {log_we[base + i], 26'd0, log_adr[base + i]}, {1'b0, 26'd0, 5'h10});
      check_eq("nom_rdrx", {log_we[base + 8], 26'd0, log_adr[base + 8]}, 32'h0);
    end

    // LSB + tx_neg mode
    base = log_adr.size();
    rx_word = 32'h1234_5675;
    run_xfer("lsb", 7'd4, 3'b110, 16'd3, 8'd2, 32'h5, 0, 32'h5, 1'b0, lat);
    check_eq("lsb_nacc", 32'(log_adr.size() - base), 32'd7);
    if (log_adr.size() - base == 7) begin
      check_eq("lsb_ctrl", log_dat[base], 32'h2C04);
      check_eq("lsb_go", log_dat[base + 4], 32'h2D04);
    end

    // Illegal lengths: no bus activity, fast error response
    c0 = cyc_total;
    run_xfer("len0", 7'd0, 3'b000, 16'd1, 8'd1, 32'h1, 0, 32'h0, 1'b1, lat);
    check_eq("len0_lat", 32'(lat <= 3), 32'd1);
    run_xfer("len33", 7'd33, 3'b000, 16'd1, 8'd1, 32'h1, 0, 32'h0, 1'b1, lat);
    check_eq("len33_lat", 32'(lat <= 3), 32'd1);
    check_eq("len_no_cyc", 32'(cyc_total - c0), 32'd0);

    // Ack timeout on the divider write
    base = log_adr.size();
    noack_en = 1'b1;
    noack_adr = 5'h14;
    run_xfer("ackto", 7'd8, 3'b000, 16'd1, 8'd1, 32'hAA, 0, 32'h0, 1'b1, lat);
    noack_en = 1'b0;
    check_eq("ackto_nacc", 32'(log_adr.size() - base), 32'd1);
    check_eq("ackto_stb_run", 32'(last_run), 32'd16);

    // Bus error on the ss write
    base = log_adr.size();
    err_en = 1'b1;
    err_adr = 5'h18;
    run_xfer("buserr", 7'd8, 3'b000, 16'd1, 8'd1, 32'hAA, 0, 32'h0, 1'b1, lat);
    err_en = 1'b0;
    check_eq("buserr_nacc", 32'(log_adr.size() - base), 32'd2);

    // go_busy never clears
    base = log_adr.size();
    busy_forever = 1'b1;
    run_xfer("busyto", 7'd4, 3'b001, 16'd2, 8'd1, 32'h236f, 0, 32'h0, 1'b1, lat);
    busy_forever = 1'b0;
    check_eq("busyto_lat", 32'(lat >= 4096), 32'd1);
    writes = 0;
    for (int i = base; i < log_adr.size(); i++) if (log_we[i]) writes++;
    check_eq("busyto_writes", 32'(writes), 32'd6);
    n = log_adr.size() - 1;
    check_eq("busyto_last", {log_we[n], 26'd0, log_adr[n]}, {1'b1, 26'd0, 5'h10});
    check_eq("busyto_last_dat", log_dat[n], 32'h2204);

    // Reset during POLL, then a full-width transfer
    busy_forever = 1'b1;
    send_req(7'd4, 3'b001, 16'd2, 8'd1, 32'h236f, c0);
    n = 0;
    while (!(wb_stb_o && !wb_we_o && wb_adr_o == 5'h10) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check_eq("rstpoll_reached", 32'(n < 200), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("rstpoll_cyc", 32'(wb_cyc_o), 32'd0);
    check_eq("rstpoll_stb", 32'(wb_stb_o), 32'd0);
    check_eq("rstpoll_dat", wb_dat_o, 32'h0);
    check_eq("rstpoll_sel", 32'(wb_sel_o), 32'd0);
    check_eq("rstpoll_ready", 32'(req_ready), 32'd0);
    busy_forever = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check_eq("rstpoll_no_rsp", 32'(rsp_valid), 32'd0);
    end
    base = log_adr.size();
    busy_until = poll_reads;
    rx_word = 32'hDEAD_BEEF;
    run_xfer("len32", 7'd32, 3'b000, 16'd4, 8'h80, 32'h1234_5678, 0, 32'hDEAD_BEEF, 1'b0, lat);
    if (log_adr.size() - base >= 5) begin
      check_eq("len32_ctrl", log_dat[base], 32'h2020);
      check_eq("len32_ss", log_dat[base + 2], 32'h80);
    end else begin
      check_eq("len32_nacc", 32'(log_adr.size() - base), 32'd7);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
